// File: rtl/store_buffer_if.sv
// Data-memory port of the store buffer.
// The buffer is the master; the memory is the slave.
interface store_buffer_if #(
  parameter int AW = 24,
  parameter int DW = 24
);
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic          MemWrite;
  logic          MemRead;
  logic [DW-1:0] MemReadData;

  modport master (
    output MemAddress,
    output MemWriteData,
    output MemWrite,
    output MemRead,
    input  MemReadData
  );

  modport slave (
    input  MemAddress,
    input  MemWriteData,
    input  MemWrite,
    input  MemRead,
    output MemReadData
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer in front of a 3-byte-word data memory.
// Loads forward from the youngest buffered store or read memory.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 24,
  parameter int DW    = 24
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic [AW-1:0]          CpuAddress,
  input  logic [DW-1:0]          CpuWriteData,
  input  logic                   CpuMemWrite,
  input  logic                   CpuMemRead,
  input  logic                   DrainReq,
  output logic [DW-1:0]          CpuReadData,
  output logic                   Stall,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty,
  store_buffer_if.master         bus
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;

  logic          is_st;
  logic          is_ld;
  logic          full;
  logic          drain;
  logic          enq;
  logic          rd_miss;
  logic          any_hit;
  logic [DW-1:0] fwd;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] ovl;

  logic [AW-1:0] ap1, ap2, am1, am2;

  assign ap1 = CpuAddress + AW'(1);
  assign ap2 = CpuAddress + AW'(2);
  assign am1 = CpuAddress - AW'(1);
  assign am2 = CpuAddress - AW'(2);

  // An entry is live when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] age;
    valid = '0;
    hit   = '0;
    ovl   = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head_q;
      valid[i] = {1'b0, age} < count_q;
      hit[i]   = valid[i] &&
                 (addr_q[i] == CpuAddress);
      ovl[i]   = valid[i] &&
                 (addr_q[i] == ap1 ||
                  addr_q[i] == ap2 ||
                  addr_q[i] == am1 ||
                  addr_q[i] == am2);
    end
  end

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd     = '0;
    any_hit = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (hit[idx]) begin
        fwd     = data_q[idx];
        any_hit = 1'b1;
      end
    end
  end

  assign is_st = CpuMemWrite;
  assign is_ld = CpuMemRead && !CpuMemWrite;
  assign Empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign Count = count_q;

  assign Stall = (DrainReq && !Empty) ||
                 (is_st && full) ||
                 (is_ld && |ovl);

  assign drain   = !Empty &&
                   (!(is_st || is_ld) || Stall);
  assign enq     = is_st && !Stall;
  assign rd_miss = is_ld && !Stall && !any_hit;

  assign CpuReadData = (is_ld && any_hit) ?
                       fwd : bus.MemReadData;

  always_comb begin
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    unique case (1'b1)
      drain: begin
        bus.MemAddress   = addr_q[head_q];
        bus.MemWriteData = data_q[head_q];
        bus.MemWrite     = 1'b1;
      end
      rd_miss: begin
        bus.MemAddress = CpuAddress;
        bus.MemRead    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enqueue and drain are mutually exclusive by construction.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq) begin
      addr_q[tail_q] <= CpuAddress;
      data_q[tail_q] <= CpuWriteData;
      tail_q         <= tail_q + PW'(1);
      count_q        <= count_q + (PW+1)'(1);
    end else if (drain) begin
      head_q  <= head_q + PW'(1);
      count_q <= count_q - (PW+1)'(1);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Random and directed checks of store_buffer against
// a program-order byte memory and a FIFO model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int DW    = 24;

  logic          Clock = 1'b0;
  logic          ResetN;
  logic [AW-1:0] CpuAddress;
  logic [DW-1:0] CpuWriteData;
  logic          CpuMemWrite;
  logic          CpuMemRead;
  logic          DrainReq;
  logic [DW-1:0] CpuReadData;
  logic          Stall;
  logic [2:0]    Count;
  logic          Empty;

  always #5 Clock = ~Clock;

  store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .CpuAddress   (CpuAddress),
    .CpuWriteData (CpuWriteData),
    .CpuMemWrite  (CpuMemWrite),
    .CpuMemRead   (CpuMemRead),
    .DrainReq     (DrainReq),
    .CpuReadData  (CpuReadData),
    .Stall        (Stall),
    .Count        (Count),
    .Empty        (Empty),
    .bus          (bus)
  );

  // Addresses stay in two 256-byte-aliasing-free windows.
  logic [7:0] mem  [256];
  logic [7:0] arch [256];

  always_comb begin
    logic [7:0] i0;
    i0 = bus.MemAddress[7:0];
    bus.MemReadData = {mem[i0],
                       mem[8'(i0 + 8'd1)],
                       mem[8'(i0 + 8'd2)]};
  end

  function automatic logic [23:0] arch_rd(input logic [23:0] a);
    logic [7:0] i0;
    i0 = a[7:0];
    return {arch[i0], arch[8'(i0 + 8'd1)], arch[8'(i0 + 8'd2)]};
  endfunction

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] d;
  } ent_t;

  ent_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_stall;
  logic        o_stall, o_mw, o_mr;
  logic [23:0] o_ma, o_md, o_rd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic rd,
                     input logic drq,
                     input logic [23:0] a,
                     input logic [23:0] d);
    bit st, ld, hit, ovl, est, edr, emiss;
    logic [23:0] diff;
    ent_t e;
    CpuMemWrite  = wr;
    CpuMemRead   = rd;
    DrainReq     = drq;
    CpuAddress   = a;
    CpuWriteData = d;
    @(negedge Clock);
    st  = wr;
    ld  = rd && !wr;
    hit = 0;
    ovl = 0;
    foreach (q[i]) begin
      diff = q[i].a - a;
      if (diff == 24'd0) hit = 1;
      if (diff == 24'd1 || diff == 24'd2 ||
          diff == 24'hFFFFFF || diff == 24'hFFFFFE)
        ovl = 1;
    end
    est   = (drq && q.size() != 0) ||
            (st && q.size() == DEPTH) ||
            (ld && ovl);
    edr   = q.size() != 0 && (!(st || ld) || est);
    emiss = ld && !est && !hit;
    o_stall = Stall;
    o_mw    = bus.MemWrite;
    o_mr    = bus.MemRead;
    o_ma    = bus.MemAddress;
    o_md    = bus.MemWriteData;
    o_rd    = CpuReadData;
    chk("stall", 32'(Stall), 32'(est));
    chk("count", 32'(Count), 32'(q.size()));
    chk("empty", 32'(Empty), 32'(q.size() == 0));
    chk("memwrite", 32'(o_mw), 32'(edr));
    chk("memread", 32'(o_mr), 32'(emiss));
    if (edr) begin
      chk("drain_addr", 32'(o_ma), 32'(q[0].a));
      chk("drain_data", 32'(o_md), 32'(q[0].d));
    end else if (emiss) begin
      chk("miss_addr", 32'(o_ma), 32'(a));
    end else begin
      chk("idle_addr", 32'(o_ma), 32'd0);
      chk("idle_wdata", 32'(o_md), 32'd0);
    end
    if (ld && !est)
      chk("load_data", 32'(o_rd), 32'(arch_rd(a)));
    m_stall = est;
    @(posedge Clock);
    if (o_mw) begin
      mem[o_ma[7:0]]              = o_md[23:16];
      mem[8'(o_ma[7:0] + 8'd1)]   = o_md[15:8];
      mem[8'(o_ma[7:0] + 8'd2)]   = o_md[7:0];
    end
    if (edr) void'(q.pop_front());
    if (st && !est) begin
      e.a = a;
      e.d = d;
      q.push_back(e);
      arch[a[7:0]]            = d[23:16];
      arch[8'(a[7:0] + 8'd1)] = d[15:8];
      arch[8'(a[7:0] + 8'd2)] = d[7:0];
    end
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < DEPTH + 2 && q.size() != 0; k++)
      cyc(1'b0, 1'b0, 1'b0, 24'd0, 24'd0);
    chk("flushed", 32'(Empty), 32'd1);
  endtask

  initial begin
    logic        hold;
    logic        wr, rd, drq;
    logic [23:0] a, d;
    int          op, nb;

    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i * 7 + 3);
      arch[i] = 8'(i * 7 + 3);
    end
    ResetN       = 1'b0;
    CpuMemWrite  = 1'b0;
    CpuMemRead   = 1'b0;
    DrainReq     = 1'b0;
    CpuAddress   = '0;
    CpuWriteData = '0;
    #1;
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_mw", 32'(bus.MemWrite), 32'd0);
    chk("rst_mr", 32'(bus.MemRead), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    #12 ResetN = 1'b1;
    @(posedge Clock);
    #1;

    // single store then retirement
    cyc(1, 0, 0, 24'h000010, 24'hABCDEF);
    cyc(0, 0, 0, 24'h0, 24'h0);
    chk("ss_mw", 32'(o_mw), 32'd1);
    chk("ss_ma", 32'(o_ma), 32'h10);
    chk("ss_md", 32'(o_md), 32'hABCDEF);
    chk("ss_empty", 32'(Empty), 32'd1);

    // youngest forwarding
    cyc(1, 0, 0, 24'h20, 24'h111111);
    cyc(1, 0, 0, 24'h20, 24'h222222);
    cyc(0, 1, 0, 24'h20, 24'h0);
    chk("yf_data", 32'(o_rd), 32'h222222);
    chk("yf_mr", 32'(o_mr), 32'd0);
    chk("yf_stall", 32'(o_stall), 32'd0);
    flush();

    // partial overlap
    cyc(1, 0, 0, 24'h30, 24'h123456);
    cyc(0, 1, 0, 24'h31, 24'h0);
    chk("po_stall", 32'(o_stall), 32'd1);
    chk("po_drain", 32'(o_ma), 32'h30);
    cyc(0, 1, 0, 24'h31, 24'h0);
    chk("po_stall2", 32'(o_stall), 32'd0);
    chk("po_mr", 32'(o_mr), 32'd1);
    chk("po_ma", 32'(o_ma), 32'h31);
    chk("po_rd", 32'(o_rd[23:8]), 32'h3456);
    flush();

    // full buffer
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 24'(24'h40 + 3 * k), 24'(k + 1));
    cyc(1, 0, 0, 24'h4C, 24'h5);
    chk("fb_stall", 32'(o_stall), 32'd1);
    chk("fb_drain", 32'(o_ma), 32'h40);
    cyc(1, 0, 0, 24'h4C, 24'h5);
    chk("fb_accept", 32'(o_stall), 32'd0);
    chk("fb_count", 32'(Count), 32'd4);
    flush();

    // address wrap overlap
    cyc(1, 0, 0, 24'hFFFFFF, 24'hC0FFEE);
    cyc(0, 1, 0, 24'h000001, 24'h0);
    chk("wr_stall", 32'(o_stall), 32'd1);
    cyc(0, 1, 0, 24'h000001, 24'h0);
    chk("wr_done", 32'(o_stall), 32'd0);
    flush();

    // explicit drain request
    for (int k = 0; k < 4; k++)
      cyc(1, 0, 0, 24'(24'h50 + 3 * k), 24'(24'hA0 + k));
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 24'h0, 24'h0);
      chk("dr_stall", 32'(o_stall), 32'd1);
      chk("dr_order", 32'(o_ma), 32'(24'h50 + 3 * k));
    end
    chk("dr_empty", 32'(Empty), 32'd1);
    cyc(0, 0, 1, 24'h0, 24'h0);
    chk("dr_release", 32'(o_stall), 32'd0);

    // asynchronous reset mid-stream
    cyc(1, 0, 0, 24'h60, 24'h010203);
    cyc(1, 0, 0, 24'h63, 24'h040506);
    cyc(1, 0, 0, 24'h66, 24'h070809);
    CpuMemWrite = 1'b0;
    #2 ResetN = 1'b0;
    #1;
    chk("ar_count", 32'(Count), 32'd0);
    chk("ar_empty", 32'(Empty), 32'd1);
    chk("ar_mw", 32'(bus.MemWrite), 32'd0);
    chk("ar_stall", 32'(Stall), 32'd0);
    q.delete();
    for (int i = 0; i < 256; i++) arch[i] = mem[i];
    @(negedge Clock);
    ResetN = 1'b1;
    @(posedge Clock);
    #1;
    cyc(0, 1, 0, 24'h60, 24'h0);
    chk("ar_load_mr", 32'(o_mr), 32'd1);
    chk("ar_load", 32'(o_rd),
        32'({mem[8'h60], mem[8'h61], mem[8'h62]}));

    // randomized traffic, requests held while stalled
    hold = 1'b0;
    wr = 0; rd = 0; drq = 0; a = '0; d = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        op  = int'($urandom_range(0, 3));
        wr  = (op == 1 || op == 3);
        rd  = (op == 2 || op == 3);
        drq = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 1) == 0)
          a = 24'($urandom_range(0, 15));
        else
          a = 24'hFFFFF0 + 24'($urandom_range(0, 15));
        d = 24'($urandom);
      end
      cyc(wr, rd, drq, a, d);
      hold = m_stall;
    end
    flush();
    nb = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== arch[i]) nb++;
    chk("mem_final", 32'(nb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
